fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Consumes the fetch/decode/execute phase strobes of the 8-bit fde sequencer.
- Drives the sequencer's enable input.
- Owns the program counter and the instruction memory read port.
- Latches the opcode byte in the fetch phase and an optional immediate byte in the decode phase, then presents both to the execute logic together with a valid flag.
- Applies taken branches at the end of the execute phase.

Parameters:
ADDR_W, 8, width of program counter and memory address
RESET_PC, 0, program counter value after reset
IMM_BIT, 7, opcode bit that, when 1, marks a two-byte instruction (immediate follows)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
fetch  input  1  sequencer fetch phase strobe
decode  input  1  sequencer decode phase strobe
execute  input  1  sequencer execute phase strobe
fde_enable  output  1  advance request to sequencer enable (combinational)
mem_rd  output  1  one-cycle read request pulse
mem_addr  output  ADDR_W  read address, equals pc
mem_data  input  8  read data, valid when mem_ready=1
mem_ready  input  1  read completion, one cycle per request
branch_taken  input  1  from execute logic, sampled only in execute phase
branch_target  input  ADDR_W  new pc when branch_taken
pc  output  ADDR_W  current program counter
instr  output  8  latched opcode
operand  output  8  latched immediate byte
instr_valid  output  1  instr/operand valid for execution

Behaviour:
- Reset (async) values: pc=RESET_PC, instr=0x00, operand=0x00, FSM=IDLE, loaded=0. Outputs mem_rd=0 and instr_valid=0 follow from these.
- mem_addr = pc at all times.
- need_read = fetch | (decode & instr[IMM_BIT]).
- FSM states: IDLE, WAIT, ADV.
- IDLE with need_read=1:
  - mem_rd=1 this cycle (the only state/condition where mem_rd is high).
  - Next state WAIT.
  - fde_enable=0.
- IDLE with need_read=0:
  - fde_enable=1 and the FSM stays in IDLE. This covers decode of a one-byte opcode, the execute phase, and the case where no strobe is active (sequencer IDLE code).
- WAIT:
  - mem_rd=0, fde_enable=0.
  - mem_ready=0: stay in WAIT, no timeout.
  - mem_ready=1 in fetch phase: instr<=mem_data, loaded<=1, operand unchanged.
  - mem_ready=1 in decode phase: operand<=mem_data.
  - Either case with mem_ready=1: pc<=pc+1 (mod 2^ADDR_W, 0xFF wraps to 0x00), next state ADV.
- ADV: fde_enable=1 for exactly one cycle, then next state IDLE. The sequencer leaves the phase on this edge.
- Minimum latency: 3 cycles for a fetch or immediate-decode phase; 1 cycle for a one-byte decode phase and for an execute phase. A fetch where mem_ready arrives the cycle after mem_rd therefore takes 3 cycles.
- mem_ready is ignored outside WAIT, including a late response after reset.
- instr_valid = execute & loaded & (FSM==IDLE).
- Execute phase with branch_taken=1: pc<=branch_target on the same edge fde_enable=1 is sampled. Branch overrides nothing else.
- branch_taken outside the execute phase is ignored.
- If more than one strobe is high (illegal), priority is fetch > decode > execute.
- Reset mid-WAIT: the request is abandoned and pc returns to RESET_PC. The sequencer is not reset by this block, so the next read issues from IDLE in whatever phase is current.
- First phase after power-up is execute. instr_valid=0 there because loaded=0, and fde_enable=1 so the sequencer proceeds to fetch.

Test Plan:
- Reset then one-byte opcode: mem[0x00]=0x12, ready 1 cycle after rd -> mem_rd pulse at addr 0x00. instr=0x12 and pc=0x01 after WAIT. fde_enable high 1 cycle in ADV, decode takes 1 cycle, instr_valid=1 in execute, operand=0x00.
- Two-byte opcode: mem[0x01]=0x85, mem[0x02]=0x3C -> two mem_rd pulses at 0x01 and 0x02. instr=0x85, operand=0x3C, pc=0x03, instr_valid=1 in execute.
- Slow memory: mem_ready delayed 4 cycles -> fde_enable stays 0 and mem_rd stays a single pulse. Fetch phase lasts 6 cycles and instr is latched on the ready cycle.
- Branch: branch_taken=1, branch_target=0x40 in execute -> next fetch mem_rd at 0x40. branch_taken=1 during decode -> ignored, pc unchanged.
- Wrap: pc=0xFF, one-byte fetch -> pc=0x00 after WAIT. A two-byte opcode at 0xFF takes its immediate from 0x00.
- Reset asserted in WAIT -> pc=0x00, mem_rd=0 and instr=0x00 immediately. A mem_ready arriving 1 cycle after reset release is ignored (instr stays 0x00).

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end for the 8-bit fde sequencer.
//
// Watches the sequencer's fetch/decode/execute phase strobes and holds the
// sequencer (fde_enable low) while a memory read is outstanding. It owns the
// program counter and latches the opcode (fetch phase) and an optional
// immediate byte (decode phase, opcode bit IMM_BIT set). Both bytes are then
// presented to the execute logic with instr_valid. A taken branch reloads the
// pc on the edge that ends the execute phase.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   fetch/decode/execute  sequencer phase strobes (priority in that order)
//   fde_enable            combinational advance request to the sequencer
//   mem_rd, mem_addr      one-cycle read request, address = pc
//   mem_data, mem_ready   read data, qualified by one-cycle mem_ready
//   branch_taken/_target  branch request, honoured in the execute phase only
//   pc                    current program counter
//   instr, operand        latched opcode and immediate byte
//   instr_valid           instr/operand valid in the execute phase
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       IMM_BIT  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              decode,
  input  logic              execute,
  output logic              fde_enable,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr,
  output logic [7:0]        operand,
  output logic              instr_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ADV
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        instr_q, instr_d;
  logic [7:0]        operand_q, operand_d;
  logic              loaded_q, loaded_d;

  logic need_read;
  logic exec_phase;

  // A memory read is needed for every fetch, and for a decode only when the
  // latched opcode announces an immediate byte.
  assign need_read  = fetch | (decode & instr_q[IMM_BIT]);
  // Execute only counts when no higher-priority strobe is also active.
  assign exec_phase = execute & ~fetch & ~decode;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      operand_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
      loaded_q  <= loaded_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    loaded_d  = loaded_q;
    unique case (state_q)
      S_IDLE: begin
        if (need_read) begin
          state_d = S_WAIT;
        end else if (exec_phase && branch_taken) begin
          // Lands on the same edge the sequencer leaves the execute phase.
          pc_d = branch_target;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_ADV;
          if (fetch) begin
            instr_d  = mem_data;
            loaded_d = 1'b1;
          end else if (decode) begin
            operand_d = mem_data;
          end
        end
      end
      S_ADV: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    // No request leaves the block while reset is held, even with fetch high.
    mem_rd      = (state_q == S_IDLE) & need_read & ~reset;
    fde_enable  = ((state_q == S_IDLE) & ~need_read) | (state_q == S_ADV);
    instr_valid = execute & loaded_q & (state_q == S_IDLE);
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign operand  = operand_q;

endmodule
